response_collector: RTL and testbench
=====================================

// Module: response_collector
// PURPOSE
//  Requester-side sink of the response NoC. Pops 25-bit response packets from the local NoC output FIFO.
//  Checks each packet against a 64-entry pending-request scoreboard, then writes the reply data to the
//  local register file at reg_id. Issue logic sets scoreboard bits as queries go out; this block clears them.
// PARAMETERS
//  DATA_W   16           reply data width
//  ID_W     6            reg_id width; scoreboard depth = 2**ID_W
//  RESP_W   DATA_W+ID_W+3  packet width (25)
//  MY_PORT  2'd0         this node's port; packets whose dest differs are dropped
// PORTS
//  clk          in   1        clock, rising edge
//  reset        in   1        asynchronous reset, active-low
//  empty        in   1        NoC output FIFO empty
//  dataIn       in   RESP_W   FIFO head; valid the cycle after read=1 (1-cycle read latency)
//  read         out  1        FIFO pop strobe
//  issue        in   1        a query with issue_id was sent this cycle
//  issue_id     in   ID_W     reg_id of issued query
//  wr_en        out  1        register-file write strobe
//  wr_addr      out  ID_W     register-file address (= reg_id)
//  wr_data      out  DATA_W   reply data
//  pending_cnt  out  ID_W+1   number of outstanding queries
//  all_done     out  1        pending_cnt==0 and FSM in IDLE
//  err_unexp    out  1        sticky: response for a non-pending reg_id
//  err_port     out  1        sticky: dest!=MY_PORT or valid bit 0
//  err_dup      out  1        sticky: issue of an already-pending id
//  err_clr      in   1        synchronous clear of all sticky errors
// BEHAVIOUR
//  Packet: [0] valid, [2:1] dest, [ID_W+2:3] reg_id, [RESP_W-1:ID_W+3] data.
//  Reset (reset==0): read=0, wr_en=0, wr_addr=0, wr_data=0, pending table all 0, pending_cnt=0,
//   all errors 0, FSM=IDLE. all_done=1 once out of reset.
//  FSM, registered outputs:
//   IDLE: if !empty -> POP with read=1 for exactly one cycle; else stay, read=0.
//   POP : read=0; sample dataIn -> CHECK.
//   CHECK: if valid==0 or dest!=MY_PORT: set err_port, no write.
//          elif pend[reg_id]==0: set err_unexp, no write.
//          else wr_en=1 for one cycle, wr_addr=reg_id, wr_data=data; clear pend[reg_id].
//          -> IDLE.
//  Throughput: one packet per 3 cycles. Latency from read to wr_en: 2 cycles.
//  read never asserts while empty=1. read never asserts in two consecutive cycles.
//  wr_addr/wr_data hold their last value when wr_en=0.
//  Scoreboard update, same edge:
//   - issue on a non-pending id: set bit, cnt+1.
//   - issue on a pending id (not being retired): err_dup=1, no change.
//   - retire only: clear bit, cnt-1.
//   - issue and retire of the same id in one cycle: bit stays 1, cnt unchanged (new query).
//   - issue and retire of different ids: both apply, cnt unchanged.
//  pending_cnt saturates at neither end. It can reach 2**ID_W, hence the ID_W+1 width.
//  err_clr has priority over any error set in the same cycle.
//  Reset mid-packet drops the in-flight packet; the FIFO entry is already popped.
// STRUCTURE
//  Shared package noc_pkg: DATA_W, ID_W, RESP_W, field offsets (VALID_B, DEST_LSB, ID_LSB, DATA_LSB),
//   state enum {IDLE, POP, CHECK}. The responder uses the same offsets.
//  One sub-module: pending_scoreboard (bit table, counter, dup detect, set/clear arbitration).
//  The FSM and the register-file write port live in the top level.
// TESTING
//  1. Reset, then empty=1 held 20 cycles -> read never 1, all_done=1, pending_cnt=0.
//  2. issue id 5; push {16'hBEEF,6'd5,2'd0,1'b1} -> read, wr_en 2 cycles later,
//     wr_addr=5, wr_data=BEEF, pending_cnt 1->0.
//  3. push packet reg_id=9 with nothing issued -> no wr_en, err_unexp=1;
//     err_clr pulse -> 0.
//  4. push dest=2'd3 (MY_PORT=0) for pending id 7 -> no write, err_port=1, id 7 still pending.
//  5. issue id 12 twice -> err_dup=1, pending_cnt=1; issue id 12 in the retire cycle of id 12
//     -> id 12 pending, cnt=1.
//  6. issue ids 0..63, FIFO back-to-back with 64 responses in random order -> 64 writes with
//     correct data, read spacing >=3, pending_cnt=64 then 0, all_done=1.

Source files
------------

// File: rtl/noc_pkg.sv
// Shared response-NoC definitions: packet geometry, field offsets and collector FSM states.
// The responder builds packets with the same offsets.
package noc_pkg;

   localparam int DATA_W   = 16;
   localparam int ID_W     = 6;
   localparam int RESP_W   = DATA_W + ID_W + 3;

   localparam int VALID_B  = 0;
   localparam int DEST_LSB = 1;
   localparam int DEST_W   = 2;
   localparam int ID_LSB   = 3;
   localparam int DATA_LSB = ID_LSB + ID_W;

   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] POP   = 2'd1;
   localparam logic [1:0] CHECK = 2'd2;

endpackage

// File: rtl/pending_scoreboard.sv
// Outstanding-query table: one bit per reg_id plus a population counter.
// Arbitrates a same-edge issue (set) against a retire (clear).
module pending_scoreboard #(
   parameter int ID_W = noc_pkg::ID_W
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            issue,
   input  logic [ID_W-1:0] issue_id,
   input  logic            retire,
   input  logic [ID_W-1:0] retire_id,
   input  logic [ID_W-1:0] query_id,
   output logic            query_hit,
   output logic            dup,
   output logic [ID_W:0]   pending_cnt,
   output logic [ID_W:0]   cnt_nxt
);

   localparam int DEPTH = 2 ** ID_W;

   logic [DEPTH-1:0] pend_r;
   logic [ID_W:0]    cnt_r;
   logic             same_s;
   logic             set_s;
   logic             clr_s;
   logic             dup_s;
   logic [ID_W:0]    cnt_nxt_s;

   // Issue and retire of the same id in one cycle is a fresh query: the bit stays set, count unchanged.
   always_comb begin
      same_s    = issue && retire && (issue_id == retire_id);
      set_s     = issue && !pend_r[issue_id];
      dup_s     = issue && pend_r[issue_id] && !same_s;
      clr_s     = retire && !same_s;
      cnt_nxt_s = cnt_r + (ID_W+1)'(set_s) - (ID_W+1)'(clr_s);
   end

   // Bit table and counter; a set and a clear never target the same id, so their order is irrelevant.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         pend_r <= '0;
         cnt_r  <= '0;
      end else begin
         if (clr_s) begin
            pend_r[retire_id] <= 1'b0;
         end
         if (set_s) begin
            pend_r[issue_id] <= 1'b1;
         end
         cnt_r <= cnt_nxt_s;
      end
   end

   assign query_hit   = pend_r[query_id];
   assign dup         = dup_s;
   assign pending_cnt = cnt_r;
   assign cnt_nxt     = cnt_nxt_s;

endmodule

// File: rtl/response_collector.sv
// Requester-side response sink: pops NoC response packets, validates them against the
// pending-query scoreboard and writes the reply data into the local register file.
module response_collector #(
   parameter int         DATA_W  = noc_pkg::DATA_W,
   parameter int         ID_W    = noc_pkg::ID_W,
   parameter int         RESP_W  = DATA_W + ID_W + 3,
   parameter logic [1:0] MY_PORT = 2'd0
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              empty,
   input  logic [RESP_W-1:0] dataIn,
   output logic              read,
   input  logic              issue,
   input  logic [ID_W-1:0]   issue_id,
   output logic              wr_en,
   output logic [ID_W-1:0]   wr_addr,
   output logic [DATA_W-1:0] wr_data,
   output logic [ID_W:0]     pending_cnt,
   output logic              all_done,
   output logic              err_unexp,
   output logic              err_port,
   output logic              err_dup,
   input  logic              err_clr
);

   import noc_pkg::*;

   localparam int D_LSB = ID_LSB + ID_W;

   logic [1:0]        state_r;
   logic [1:0]        state_nxt_s;
   logic              read_r;
   logic              read_nxt_s;
   logic              wr_en_r;
   logic              wr_en_nxt_s;
   logic [ID_W-1:0]   wr_addr_r;
   logic [DATA_W-1:0] wr_data_r;
   logic              err_unexp_r;
   logic              err_port_r;
   logic              err_dup_r;
   logic              all_done_r;
   logic              retire_s;
   logic              port_bad_s;
   logic              unexp_s;
   logic              hit_s;
   logic              dup_s;
   logic [ID_W:0]     cnt_nxt_s;

   logic              pkt_valid_s;
   logic [1:0]        pkt_dest_s;
   logic [ID_W-1:0]   pkt_id_s;
   logic [DATA_W-1:0] pkt_data_s;

   // dataIn holds the popped packet during CHECK (one cycle after read).
   assign pkt_valid_s = dataIn[VALID_B];
   assign pkt_dest_s  = dataIn[DEST_LSB +: DEST_W];
   assign pkt_id_s    = dataIn[ID_LSB +: ID_W];
   assign pkt_data_s  = dataIn[D_LSB +: DATA_W];

   pending_scoreboard #(
      .ID_W (ID_W)
   ) u_scoreboard (
      .clk         (clk),
      .reset       (reset),
      .issue       (issue),
      .issue_id    (issue_id),
      .retire      (retire_s),
      .retire_id   (pkt_id_s),
      .query_id    (pkt_id_s),
      .query_hit   (hit_s),
      .dup         (dup_s),
      .pending_cnt (pending_cnt),
      .cnt_nxt     (cnt_nxt_s)
   );

   // Next-state and per-packet decision logic.
   always_comb begin
      state_nxt_s = IDLE;
      read_nxt_s  = 1'b0;
      wr_en_nxt_s = 1'b0;
      retire_s    = 1'b0;
      port_bad_s  = 1'b0;
      unexp_s     = 1'b0;
      case (state_r)
         IDLE: begin
            if (!empty) begin
               state_nxt_s = POP;
               read_nxt_s  = 1'b1;
            end else begin
               state_nxt_s = IDLE;
               read_nxt_s  = 1'b0;
            end
         end
         POP: begin
            state_nxt_s = CHECK;
         end
         CHECK: begin
            state_nxt_s = IDLE;
            if (!pkt_valid_s || (pkt_dest_s != MY_PORT)) begin
               port_bad_s = 1'b1;
            end else if (!hit_s) begin
               unexp_s = 1'b1;
            end else begin
               wr_en_nxt_s = 1'b1;
               retire_s    = 1'b1;
            end
         end
         default: begin
            state_nxt_s = IDLE;
         end
      endcase
   end

   // FSM state and registered FIFO / register-file strobes.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_r    <= IDLE;
         read_r     <= 1'b0;
         wr_en_r    <= 1'b0;
         wr_addr_r  <= '0;
         wr_data_r  <= '0;
         all_done_r <= 1'b0;
      end else begin
         state_r    <= state_nxt_s;
         read_r     <= read_nxt_s;
         wr_en_r    <= wr_en_nxt_s;
         all_done_r <= (cnt_nxt_s == '0) && (state_nxt_s == IDLE);
         if (wr_en_nxt_s) begin
            wr_addr_r <= pkt_id_s;
            wr_data_r <= pkt_data_s;
         end
      end
   end

   // Sticky error flags; a clear wins over a set arriving on the same edge.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         err_unexp_r <= 1'b0;
         err_port_r  <= 1'b0;
         err_dup_r   <= 1'b0;
      end else if (err_clr) begin
         err_unexp_r <= 1'b0;
         err_port_r  <= 1'b0;
         err_dup_r   <= 1'b0;
      end else begin
         err_unexp_r <= err_unexp_r | unexp_s;
         err_port_r  <= err_port_r | port_bad_s;
         err_dup_r   <= err_dup_r | dup_s;
      end
   end

   assign read      = read_r;
   assign wr_en     = wr_en_r;
   assign wr_addr   = wr_addr_r;
   assign wr_data   = wr_data_r;
   assign all_done  = all_done_r;
   assign err_unexp = err_unexp_r;
   assign err_port  = err_port_r;
   assign err_dup   = err_dup_r;

endmodule

// File: tb/tb_response_collector.sv
// Directed scoreboard bench for response_collector: FIFO model with 1-cycle read latency,
// an expected-write queue filled by stimulus and drained by an independent monitor.
module tb_response_collector;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        empty;
   logic [24:0] dataIn = 25'd0;
   logic        read;
   logic        issue = 1'b0;
   logic [5:0]  issue_id = 6'd0;
   logic        wr_en;
   logic [5:0]  wr_addr;
   logic [15:0] wr_data;
   logic [6:0]  pending_cnt;
   logic        all_done;
   logic        err_unexp;
   logic        err_port;
   logic        err_dup;
   logic        err_clr = 1'b0;

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int wr_total = 0;
   int wr_target = 0;
   int last_read = -100;

   logic [24:0] fifo_mem [0:511];
   int push_cnt = 0;
   int pop_cnt = 0;
   logic [21:0] exp_q [$];

   response_collector dut (
      .clk         (clk),
      .reset       (reset),
      .empty       (empty),
      .dataIn      (dataIn),
      .read        (read),
      .issue       (issue),
      .issue_id    (issue_id),
      .wr_en       (wr_en),
      .wr_addr     (wr_addr),
      .wr_data     (wr_data),
      .pending_cnt (pending_cnt),
      .all_done    (all_done),
      .err_unexp   (err_unexp),
      .err_port    (err_port),
      .err_dup     (err_dup),
      .err_clr     (err_clr)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // FIFO model: head appears on dataIn the cycle after a pop
   assign empty = (push_cnt == pop_cnt);
   always @(posedge clk) begin
      if (read) begin
         dataIn  <= fifo_mem[pop_cnt % 512];
         pop_cnt <= pop_cnt + 1;
      end
   end

   // Monitor: FIFO protocol and register-file writes against the expected queue
   always @(negedge clk) begin
      if (reset) begin
         if (read) begin
            checks++;
            if (empty || (cyc - last_read < 3)) begin
               errors++;
               $display("FAIL read_protocol: empty=%0b spacing=%0d, required empty=0 spacing>=3",
                        empty, cyc - last_read);
            end
            last_read = cyc;
         end
         if (wr_en) begin
            checks++;
            wr_total++;
            if (exp_q.size() == 0) begin
               errors++;
               $display("FAIL unexpected_write: addr=%0d data=%h, required no write", wr_addr, wr_data);
            end else begin
               logic [21:0] e;
               e = exp_q.pop_front();
               if ({wr_addr, wr_data} !== e || (cyc - last_read) != 2) begin
                  errors++;
                  $display("FAIL write: addr=%0d data=%h latency=%0d, required addr=%0d data=%h latency=2",
                           wr_addr, wr_data, cyc - last_read, e[21:16], e[15:0]);
               end
            end
         end
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, required %0h", name, act, exp);
      end
   endtask

   function automatic logic [24:0] pkt(input logic [15:0] d, input logic [5:0] id,
                                       input logic [1:0] dest, input logic v);
      return {d, id, dest, v};
   endfunction

   task automatic push(input logic [24:0] p);
      fifo_mem[push_cnt % 512] = p;
      push_cnt++;
   endtask

   task automatic push_good(input logic [5:0] id, input logic [15:0] d);
      exp_q.push_back({id, d});
      wr_target++;
      push(pkt(d, id, 2'd0, 1'b1));
   endtask

   task automatic do_issue(input logic [5:0] id);
      issue    = 1'b1;
      issue_id = id;
      @(negedge clk);
      issue    = 1'b0;
   endtask

   task automatic pulse_clr();
      err_clr = 1'b1;
      @(negedge clk);
      err_clr = 1'b0;
   endtask

   task automatic wait_writes(input int budget);
      int n = 0;
      while (wr_total < wr_target && n < budget) begin
         @(negedge clk);
         n++;
      end
      chk("write_timeout", 32'(wr_total), 32'(wr_target));
   endtask

   initial begin
      // 1: reset values, then idle with an empty FIFO
      repeat (3) @(negedge clk);
      chk("rst_read", 32'(read), 32'd0);
      chk("rst_wr_en", 32'(wr_en), 32'd0);
      chk("rst_wr_addr", 32'(wr_addr), 32'd0);
      chk("rst_wr_data", 32'(wr_data), 32'd0);
      chk("rst_cnt", 32'(pending_cnt), 32'd0);
      chk("rst_errs", 32'({err_unexp, err_port, err_dup}), 32'd0);
      reset = 1'b1;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         chk("idle_read", 32'(read), 32'd0);
      end
      chk("idle_all_done", 32'(all_done), 32'd1);
      chk("idle_cnt", 32'(pending_cnt), 32'd0);

      // 2: normal response for issued id 5
      do_issue(6'd5);
      chk("t2_cnt_up", 32'(pending_cnt), 32'd1);
      chk("t2_not_done", 32'(all_done), 32'd0);
      push_good(6'd5, 16'hBEEF);
      wait_writes(20);
      chk("t2_cnt_down", 32'(pending_cnt), 32'd0);
      chk("t2_all_done", 32'(all_done), 32'd1);

      // 3: response for a non-pending id
      push(pkt(16'h1234, 6'd9, 2'd0, 1'b1));
      repeat (8) @(negedge clk);
      chk("t3_err_unexp", 32'(err_unexp), 32'd1);
      chk("t3_no_write", 32'(wr_total), 32'(wr_target));
      pulse_clr();
      chk("t3_err_cleared", 32'(err_unexp), 32'd0);

      // 4: wrong dest, then valid=0, for pending id 7
      do_issue(6'd7);
      push(pkt(16'h7777, 6'd7, 2'd3, 1'b1));
      repeat (8) @(negedge clk);
      chk("t4_err_port_dest", 32'(err_port), 32'd1);
      chk("t4_still_pending", 32'(pending_cnt), 32'd1);
      pulse_clr();
      chk("t4_err_cleared", 32'(err_port), 32'd0);
      push(pkt(16'h5555, 6'd7, 2'd0, 1'b0));
      repeat (8) @(negedge clk);
      chk("t4_err_port_valid", 32'({err_port, err_unexp}), 32'd2);
      chk("t4_still_pending2", 32'(pending_cnt), 32'd1);
      pulse_clr();
      push_good(6'd7, 16'h7007);
      wait_writes(20);
      chk("t4_retired", 32'(pending_cnt), 32'd0);

      // 5: duplicate issue, then issue in the retire cycle of the same id
      do_issue(6'd12);
      chk("t5_no_dup", 32'(err_dup), 32'd0);
      do_issue(6'd12);
      chk("t5_err_dup", 32'(err_dup), 32'd1);
      chk("t5_cnt_one", 32'(pending_cnt), 32'd1);
      pulse_clr();
      chk("t5_dup_cleared", 32'(err_dup), 32'd0);
      push_good(6'd12, 16'hC0DE);
      begin
         int n = 0;
         while (!read && n < 20) begin
            @(negedge clk);
            n++;
         end
         chk("t5_read_seen", 32'(read), 32'd1);
      end
      @(negedge clk);
      do_issue(6'd12);
      wait_writes(20);
      chk("t5_reissue_cnt", 32'(pending_cnt), 32'd1);
      chk("t5_reissue_no_dup", 32'(err_dup), 32'd0);
      push_good(6'd12, 16'hD00D);
      wait_writes(20);
      chk("t5_final_cnt", 32'(pending_cnt), 32'd0);

      // 6: all 64 ids outstanding, responses back-to-back in permuted order
      for (int i = 0; i < 64; i++) do_issue(6'(i));
      chk("t6_cnt_full", 32'(pending_cnt), 32'd64);
      chk("t6_not_done", 32'(all_done), 32'd0);
      for (int i = 0; i < 64; i++) begin
         logic [5:0] id;
         id = 6'((i * 37) % 64);
         push_good(id, 16'(id * 131) ^ 16'h5A5A);
      end
      wait_writes(400);
      repeat (2) @(negedge clk);
      chk("t6_cnt_empty", 32'(pending_cnt), 32'd0);
      chk("t6_all_done", 32'(all_done), 32'd1);
      chk("t6_no_errs", 32'({err_unexp, err_port, err_dup}), 32'd0);
      chk("t6_queue_drained", 32'(exp_q.size()), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
